// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: queues ALU commands, issues them to a combinational ALU, returns results in order.
// Optional stat counters are enabled with `define ALU_CMD_ISSUER_STATS_EN.
module alu_cmd_issuer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_opcode,
    input  logic [7:0]  cmd_a,
    input  logic [7:0]  cmd_b,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [2:0]  alu_opcode,
    input  logic [7:0]  alu_result,
    input  logic [15:0] alu_mulresult,
    input  logic        alu_carry,
    input  logic        alu_zero,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic [2:0]  rsp_opcode,
    output logic        rsp_carry,
    output logic        rsp_zero,
`ifdef ALU_CMD_ISSUER_STATS_EN
    output logic [15:0] stat_rsp_cnt,
    output logic [7:0]  stat_dz_cnt,
`endif
    output logic        busy
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [2:0]  mem_op [DEPTH];
    logic [7:0]  mem_a  [DEPTH];
    logic [7:0]  mem_b  [DEPTH];
    logic [AW:0] wptr, rptr;
    logic        full, empty;
    logic        rdy_en;
    logic        push, pop;
    logic        capture, rsp_drop;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) &&
                   (wptr[AW-1:0] == rptr[AW-1:0]);

    // cmd_ready stays low while in reset and for no longer than one edge after
    assign cmd_ready = rdy_en && !full;
    assign push      = cmd_valid && cmd_ready;
    assign busy      = (state_q != IDLE) || !empty;

    // Enable acceptance on the first edge after reset release
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rdy_en <= 1'b0;
        else     rdy_en <= 1'b1;
    end

    // Command storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (push) begin
            mem_op[wptr[AW-1:0]] <= cmd_opcode;
            mem_a[wptr[AW-1:0]]  <= cmd_a;
            mem_b[wptr[AW-1:0]]  <= cmd_b;
        end
    end

    // FIFO pointers; the extra MSB separates full from empty
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
        end
    end

    // Sequencer state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next state: issue from head, let ALU settle, hold response until taken
    always_comb begin
        state_d  = state_q;
        pop      = 1'b0;
        capture  = 1'b0;
        rsp_drop = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                capture = 1'b1;
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_drop = 1'b1;
                    if (!empty) begin
                        pop     = 1'b1;
                        state_d = EXEC;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ALU operand registers; they keep the last issued command between issues
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a      <= '0;
            alu_b      <= '0;
            alu_opcode <= '0;
        end else if (pop) begin
            alu_a      <= mem_a[rptr[AW-1:0]];
            alu_b      <= mem_b[rptr[AW-1:0]];
            alu_opcode <= mem_op[rptr[AW-1:0]];
        end
    end

    // Response registers: capture settled ALU outputs, hold until handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_opcode <= '0;
            rsp_carry  <= 1'b0;
            rsp_zero   <= 1'b0;
        end else if (capture) begin
            rsp_valid  <= 1'b1;
            rsp_data   <= (alu_opcode == 3'b010) ? alu_mulresult
                                                 : {8'h00, alu_result};
            rsp_opcode <= alu_opcode;
            rsp_carry  <= alu_carry;
            rsp_zero   <= alu_zero;
        end else if (rsp_drop) begin
            rsp_valid  <= 1'b0;
        end
    end

`ifdef ALU_CMD_ISSUER_STATS_EN
    // Handshake counter wraps; divide-by-zero counter saturates
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_rsp_cnt <= '0;
            stat_dz_cnt  <= '0;
        end else begin
            if (rsp_valid && rsp_ready)
                stat_rsp_cnt <= stat_rsp_cnt + 16'd1;
            if (capture && alu_opcode == 3'b011 &&
                alu_b == 8'h00 && stat_dz_cnt != 8'hFF)
                stat_dz_cnt <= stat_dz_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// tb_alu_cmd_issuer: directed vector table plus reset, backpressure and stats sequences.
// Includes a behavioural 8-bit ALU feeding the DUT's alu_* inputs.
module tb_alu_cmd_issuer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_opcode;
    logic [7:0]  cmd_a, cmd_b;
    logic [7:0]  alu_a, alu_b;
    logic [2:0]  alu_opcode;
    logic [7:0]  alu_result;
    logic [15:0] alu_mulresult;
    logic        alu_carry, alu_zero;
    logic        rsp_valid, rsp_ready;
    logic [15:0] rsp_data;
    logic [2:0]  rsp_opcode;
    logic        rsp_carry, rsp_zero;
    logic        busy;
`ifdef ALU_CMD_ISSUER_STATS_EN
    logic [15:0] stat_rsp_cnt;
    logic [7:0]  stat_dz_cnt;
`endif

    int checks = 0;
    int errors = 0;

    alu_cmd_issuer #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_opcode(cmd_opcode), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
        .alu_result(alu_result), .alu_mulresult(alu_mulresult),
        .alu_carry(alu_carry), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_opcode(rsp_opcode),
        .rsp_carry(rsp_carry), .rsp_zero(rsp_zero),
`ifdef ALU_CMD_ISSUER_STATS_EN
        .stat_rsp_cnt(stat_rsp_cnt), .stat_dz_cnt(stat_dz_cnt),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: divide by zero yields 0xFF, mul zero flag from product
    logic [8:0]  r9;
    logic [15:0] mres;
    always_comb begin
        r9   = '0;
        mres = '0;
        case (alu_opcode)
            3'b000: r9 = {1'b0, alu_a} + {1'b0, alu_b};
            3'b001: r9 = {1'b0, alu_a} - {1'b0, alu_b};
            3'b010: begin
                mres = 16'(alu_a) * 16'(alu_b);
                r9   = {1'b0, mres[7:0]};
            end
            3'b011: r9 = (alu_b == 8'h00) ? 9'h0FF : {1'b0, alu_a / alu_b};
            3'b100: r9 = {1'b0, alu_a & alu_b};
            3'b101: r9 = {1'b0, alu_a | alu_b};
            3'b110: r9 = {1'b0, ~alu_a};
            default: r9 = {1'b0, alu_a ^ alu_b};
        endcase
        alu_result    = r9[7:0];
        alu_carry     = r9[8];
        alu_mulresult = mres;
        alu_zero      = (alu_opcode == 3'b010) ? (mres == 16'h0)
                                               : (r9[7:0] == 8'h0);
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_cmd_ready"}, 32'(cmd_ready), 0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
        chk({tag, "_rsp_data"}, 32'(rsp_data), 0);
        chk({tag, "_rsp_flags"}, 32'({rsp_opcode, rsp_carry, rsp_zero}), 0);
        chk({tag, "_alu_ops"}, 32'({alu_opcode, alu_a, alu_b}), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
`ifdef ALU_CMD_ISSUER_STATS_EN
        chk({tag, "_stats"}, 32'({stat_rsp_cnt, stat_dz_cnt}), 0);
`endif
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] data;
        logic        cy;
        logic        z;
    } vec_t;

    vec_t vecs [12];

    // Single command with an idle pipeline; returns cycles from accept to rsp_valid
    task automatic run_one(input logic [2:0] op, input logic [7:0] a,
                           input logic [7:0] b, output int lat);
        @(negedge clk);
        cmd_valid  = 1'b1;
        cmd_opcode = op;
        cmd_a      = a;
        cmd_b      = b;
        chk("cmd_ready_idle", 32'(cmd_ready), 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int lat, acc, n, last, seen;

        vecs[0]  = '{3'b000, 8'd200, 8'd100, 16'h002C, 1'b1, 1'b0};
        vecs[1]  = '{3'b010, 8'h10,  8'h10,  16'h0100, 1'b0, 1'b0};
        vecs[2]  = '{3'b011, 8'd7,   8'd0,   16'h00FF, 1'b0, 1'b0};
        vecs[3]  = '{3'b001, 8'd5,   8'd5,   16'h0000, 1'b0, 1'b1};
        vecs[4]  = '{3'b001, 8'd3,   8'd5,   16'h00FE, 1'b1, 1'b0};
        vecs[5]  = '{3'b100, 8'hF0,  8'h3C,  16'h0030, 1'b0, 1'b0};
        vecs[6]  = '{3'b101, 8'hF0,  8'h0F,  16'h00FF, 1'b0, 1'b0};
        vecs[7]  = '{3'b110, 8'hFF,  8'h00,  16'h0000, 1'b0, 1'b1};
        vecs[8]  = '{3'b111, 8'hAA,  8'h55,  16'h00FF, 1'b0, 1'b0};
        vecs[9]  = '{3'b011, 8'd100, 8'd7,   16'h000E, 1'b0, 1'b0};
        vecs[10] = '{3'b000, 8'hFF,  8'h01,  16'h0000, 1'b1, 1'b1};
        vecs[11] = '{3'b010, 8'hFF,  8'hFF,  16'hFE01, 1'b0, 1'b0};

        rst        = 1'b1;
        cmd_valid  = 1'b0;
        cmd_opcode = '0;
        cmd_a      = '0;
        cmd_b      = '0;
        rsp_ready  = 1'b1;
        #1;
        chk_all_zero("por");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("por_ready_after", 32'(cmd_ready), 1);

        // Vector table, one command at a time
        for (int i = 0; i < 12; i++) begin
            run_one(vecs[i].op, vecs[i].a, vecs[i].b, lat);
            chk($sformatf("v%0d_latency", i), 32'(lat), 2);
            chk($sformatf("v%0d_data", i), 32'(rsp_data), 32'(vecs[i].data));
            chk($sformatf("v%0d_carry", i), 32'(rsp_carry), 32'(vecs[i].cy));
            chk($sformatf("v%0d_zero", i), 32'(rsp_zero), 32'(vecs[i].z));
            chk($sformatf("v%0d_opcode", i), 32'(rsp_opcode), 32'(vecs[i].op));
        end

        // Backpressure: hold rsp_ready low and keep offering commands
        @(negedge clk);
        rsp_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 10; c++) begin
            if (acc < 7) begin
                cmd_valid  = 1'b1;
                cmd_opcode = 3'b000;
                cmd_a      = 8'(10 * acc + 1);
                cmd_b      = 8'(acc);
                if (cmd_ready) acc++;
            end
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        chk("bp_accepted", 32'(acc), 5);
        chk("bp_cmd_ready", 32'(cmd_ready), 0);
        chk("bp_rsp_valid", 32'(rsp_valid), 1);
        repeat (3) @(negedge clk);
        chk("bp_hold_data", 32'(rsp_data), 1);
        chk("bp_hold_valid", 32'(rsp_valid), 1);
        chk("bp_hold_alu_a", 32'(alu_a), 1);

        rsp_ready = 1'b1;
        n = 0;
        last = 0;
        for (int cyc = 0; cyc < 40 && n < 5; cyc++) begin
            if (rsp_valid) begin
                chk($sformatf("bp_rsp%0d_data", n), 32'(rsp_data),
                    32'(11 * n + 1));
                if (n > 0)
                    chk($sformatf("bp_rsp%0d_gap", n), 32'(cyc - last), 2);
                last = cyc;
                n++;
            end
            @(negedge clk);
        end
        chk("bp_rsp_count", 32'(n), 5);
        repeat (3) @(negedge clk);
        chk("bp_drained_busy", 32'(busy), 0);
        chk("bp_drained_valid", 32'(rsp_valid), 0);
`ifdef ALU_CMD_ISSUER_STATS_EN
        chk("stat_rsp_cnt_17", 32'(stat_rsp_cnt), 17);
        chk("stat_dz_cnt_1", 32'(stat_dz_cnt), 1);
`endif

        // Reset with a response pending and commands queued
        rsp_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cmd_valid  = 1'b1;
            cmd_opcode = 3'b101;
            cmd_a      = 8'h80 | 8'(k);
            cmd_b      = 8'h01;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("mid_pre_valid", 32'(rsp_valid), 1);
        chk("mid_pre_busy", 32'(busy), 1);
        rst = 1'b1;
        #1;
        chk_all_zero("mid");
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_ready_still_low", 32'(cmd_ready), 0);
        @(negedge clk);
        chk("mid_ready_up", 32'(cmd_ready), 1);
        chk("mid_busy", 32'(busy), 0);
        rsp_ready = 1'b1;
        seen = 0;
        repeat (6) begin
            if (rsp_valid) seen++;
            @(negedge clk);
        end
        chk("mid_no_stale_rsp", 32'(seen), 0);

`ifdef ALU_CMD_ISSUER_STATS_EN
        // Divide-by-zero counter saturation
        for (int k = 0; k < 256; k++) begin
            run_one(3'b011, 8'd7, 8'd0, lat);
            if (k == 0)
                chk("stat_dz_first", 32'(stat_dz_cnt), 1);
        end
        @(negedge clk);
        chk("stat_dz_sat", 32'(stat_dz_cnt), 32'hFF);
        chk("stat_rsp_256", 32'(stat_rsp_cnt), 256);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
